ps2_scancode_decoder: RTL and testbench
=======================================

# ps2_scancode_decoder

Consumes raw PS/2 set-2 scan-code bytes from the keyboard receiver FIFO and turns them into key make/break events. It also keeps a held-key bitmap for the game controls (WASD and arrows). It sits directly downstream of the PS/2 receiver: it pulls bytes with the receiver's active-low read strobe and presents decoded events to the CPU I/O space and the game logic.

## Interface
- No parameters.
- `clk` input 1: system clock, 50 MHz; all logic on posedge.
- `clrn` input 1: asynchronous active-low reset.
- `kb_data` input 8: byte at head of receiver FIFO; valid while `kb_ready`=1.
- `kb_ready` input 1: receiver FIFO non-empty.
- `kb_overflow` input 1: receiver FIFO overflow flag.
- `kb_rdn` output 1: active-low read strobe to receiver; registered; low for exactly one cycle per byte.
- `key_valid` output 1: one-cycle pulse; event fields below are valid.
- `key_code` output 8: final (non-prefix) scan code of the event; held until next event.
- `key_ext` output 1: event was E0-prefixed; held.
- `key_break` output 1: event was F0-prefixed (release); held.
- `key_state` output 8: held keys. Bits 0–3 are W(1D), A(1C), S(1B), D(23); bits 4–7 are E0+Up(75), Left(6B), Down(72), Right(74).
- `sync_lost` output 1: sticky; set on `kb_overflow` or on BAT/error byte; cleared by reset only.
- `key_ascii` output 8: see Configuration.

## Operation
- FSM has 3 states: IDLE, FETCH, DECODE.
  - IDLE: if `kb_ready`=1, go to FETCH, and `kb_rdn` goes low in the FETCH cycle.
  - FETCH: `kb_rdn`=0; latch `kb_data` into byte register at the end of the cycle; go to DECODE.
  - DECODE: `kb_rdn`=1; process byte; go to IDLE. The DECODE cycle lets the receiver's `kb_ready` settle after its pointer increment.
- Prefix flags `ext_f` and `brk_f` are internal.
- Byte processing (priority order):
  - Skip counter nonzero: decrement it; no event. The counter absorbs the Pause sequence.
  - E1: load skip counter with 7; clear flags.
  - E0: set `ext_f`.
  - F0: set `brk_f`.
  - AA, FA, FE, EE, 00, FF: no event; clear flags. AA, FE, 00 and FF also set `sync_lost` and clear `key_state`.
  - Any other byte: pulse `key_valid`; load `key_code`=byte, `key_ext`=`ext_f`, `key_break`=`brk_f`; clear both flags.
    - If the (ext, code) pair maps to a `key_state` bit, set that bit on make and clear it on break.
    - Unmapped codes and wrong-ext matches leave `key_state` unchanged.
- `kb_overflow`=1 in any cycle:
  - set `sync_lost`;
  - clear `ext_f`, `brk_f` and the skip counter;
  - `key_state` is unchanged.
- Repeated make (typematic) re-pulses `key_valid`; the `key_state` bit stays 1.

## Timing
- Reset values: `kb_rdn`=1; `key_valid`=0; `key_code`=00; `key_ext`=0; `key_break`=0; `key_state`=00; `sync_lost`=0; `key_ascii`=00. FSM resets to IDLE; flags, skip counter and shift state reset to 0.
- Latency: `kb_ready` rises in cycle N → `kb_rdn` low in N+1 → byte decoded in N+2 → `key_valid`, fields and `key_state` update visible in N+3.
- Throughput is at most one byte per 3 cycles. With `kb_ready` held high, `kb_rdn` pulses every 3rd cycle.
- `kb_rdn` is never low for two consecutive cycles, and never low while in IDLE or DECODE.
- Reset asserted mid-FETCH: `kb_rdn` returns high immediately (async). The byte may have been consumed by the receiver and is dropped.

## Configuration
- Macro: `PS2_SCANCODE_ASCII_EN`.
- Defined:
  - Shift-held state tracks make/break of 12 and 59 (unextended).
  - On every unextended make event, `key_ascii` loads the set-2 ASCII translation. This covers letters (lowercase, uppercase while shift held), digits 0–9, space (29→20) and enter (5A→0D). All other events load 00.
  - `key_ascii` is updated in the same cycle as `key_valid`.
- Undefined: no shift tracking logic; `key_ascii` is a constant 00.

## Test plan
- Byte 1D → one `key_valid` pulse with `key_code`=1D, `key_ext`=0, `key_break`=0; `key_state`=01. Then F0,1D → pulse with `key_break`=1; `key_state`=00.
- Bytes E0,75 then E0,F0,75 → two pulses, both `key_ext`=1, `key_code`=75. `key_state` goes 10 → 00; no pulse for prefix bytes.
- Bytes E1,14,77,E1,F0,14,F0,77 then 1C → exactly one pulse total, with `key_code`=1C; `key_state`=02.
- 4 bytes queued with `kb_ready` held high → exactly 4 single-cycle `kb_rdn` lows, 3 cycles apart. Events appear in order, each 2 cycles after its `kb_rdn` low.
- Pulse `kb_overflow` between E0 and 75 → `sync_lost`=1; the 75 event has `key_ext`=0. Byte AA → `sync_lost` remains 1; `key_state`=00.
- With `PS2_SCANCODE_ASCII_EN`: 1C → `key_ascii`=61; 12,1C → 41; F0,12,1C → 61. Assert `clrn` low mid-FETCH → all outputs return to reset values within the same cycle.

Source files
------------

// File: rtl/ps2_scancode_decoder.sv
// rtl/ps2_scancode_decoder.sv - PS/2 set-2 scan-code to key make/break event decoder
//
// Pulls bytes from the PS/2 receiver FIFO and turns prefix sequences into
// single key events. It also keeps a held-key bitmap for the game controls.
// Optional ASCII translation is enabled by defining PS2_SCANCODE_ASCII_EN.
//
// Ports:
//   clk          system clock, all logic on posedge
//   clrn         asynchronous active-low reset
//   kb_data      byte at head of receiver FIFO, valid while kb_ready=1
//   kb_ready     receiver FIFO non-empty
//   kb_overflow  receiver FIFO overflow flag
//   kb_rdn       registered active-low read strobe, one cycle per byte
//   key_valid    one-cycle event pulse
//   key_code     final scan code of the last event (held)
//   key_ext      last event was E0-prefixed (held)
//   key_break    last event was a release (held)
//   key_state    held keys: W A S D, ext Up Left Down Right
//   sync_lost    sticky; overflow or BAT/error byte seen
//   key_ascii    ASCII of last unextended make (00 when feature disabled)

module ps2_scancode_decoder (
  input  logic       clk,
  input  logic       clrn,
  input  logic [7:0] kb_data,
  input  logic       kb_ready,
  input  logic       kb_overflow,
  output logic       kb_rdn,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_break,
  output logic [7:0] key_state,
  output logic       sync_lost,
  output logic [7:0] key_ascii
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_DECODE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic       kb_rdn_q, kb_rdn_d;
  logic [7:0] byte_q, byte_d;
  logic       ext_f_q, ext_f_d;
  logic       brk_f_q, brk_f_d;
  logic [2:0] skip_q, skip_d;
  logic       key_valid_q, key_valid_d;
  logic [7:0] key_code_q, key_code_d;
  logic       key_ext_q, key_ext_d;
  logic       key_break_q, key_break_d;
  logic [7:0] key_state_q, key_state_d;
  logic       sync_lost_q, sync_lost_d;
  logic [7:0] hit_mask;

  // key_state bit selected by an (ext, code) pair; zero for unmapped keys.
  function automatic logic [7:0] state_mask(input logic ext, input logic [7:0] code);
    logic [7:0] m;
    m = 8'h00;
    case ({ext, code})
      9'h01D: m = 8'h01;
      9'h01C: m = 8'h02;
      9'h01B: m = 8'h04;
      9'h023: m = 8'h08;
      9'h175: m = 8'h10;
      9'h16B: m = 8'h20;
      9'h172: m = 8'h40;
      9'h174: m = 8'h80;
      default: m = 8'h00;
    endcase
    return m;
  endfunction

  assign hit_mask = state_mask(ext_f_q, byte_q);

  // Sequencer: one byte per IDLE -> FETCH -> DECODE round.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (kb_ready) state_d = ST_FETCH;
      ST_FETCH:  state_d = ST_DECODE;
      ST_DECODE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    // Strobe is registered from the next state so it is low exactly in FETCH.
    kb_rdn_d = (state_d != ST_FETCH);
    byte_d   = (state_q == ST_FETCH) ? kb_data : byte_q;
  end

  // Byte interpretation, done in the DECODE cycle.
  always_comb begin
    ext_f_d     = ext_f_q;
    brk_f_d     = brk_f_q;
    skip_d      = skip_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    key_ext_d   = key_ext_q;
    key_break_d = key_break_q;
    key_state_d = key_state_q;
    sync_lost_d = sync_lost_q;

    if (state_q == ST_DECODE) begin
      if (skip_q != 3'd0) begin
        // Swallowing the remainder of the Pause sequence.
        skip_d = skip_q - 3'd1;
      end else begin
        case (byte_q)
          8'hE1: begin
            skip_d  = 3'd7;
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
          end
          8'hE0: ext_f_d = 1'b1;
          8'hF0: brk_f_d = 1'b1;
          8'hFA, 8'hEE: begin
            ext_f_d = 1'b0;
            brk_f_d = 1'b0;
          end
          8'hAA, 8'hFE, 8'h00, 8'hFF: begin
            // Keyboard reset or error: held-key picture can no longer be trusted.
            ext_f_d     = 1'b0;
            brk_f_d     = 1'b0;
            sync_lost_d = 1'b1;
            key_state_d = 8'h00;
          end
          default: begin
            key_valid_d = 1'b1;
            key_code_d  = byte_q;
            key_ext_d   = ext_f_q;
            key_break_d = brk_f_q;
            ext_f_d     = 1'b0;
            brk_f_d     = 1'b0;
            if (brk_f_q) key_state_d = key_state_q & ~hit_mask;
            else         key_state_d = key_state_q | hit_mask;
          end
        endcase
      end
    end

    // An overflow means bytes were lost, so any partial sequence is void.
    if (kb_overflow) begin
      sync_lost_d = 1'b1;
      ext_f_d     = 1'b0;
      brk_f_d     = 1'b0;
      skip_d      = 3'd0;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      kb_rdn_q    <= 1'b1;
      byte_q      <= 8'h00;
      ext_f_q     <= 1'b0;
      brk_f_q     <= 1'b0;
      skip_q      <= 3'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_break_q <= 1'b0;
      key_state_q <= 8'h00;
      sync_lost_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      kb_rdn_q    <= kb_rdn_d;
      byte_q      <= byte_d;
      ext_f_q     <= ext_f_d;
      brk_f_q     <= brk_f_d;
      skip_q      <= skip_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      key_ext_q   <= key_ext_d;
      key_break_q <= key_break_d;
      key_state_q <= key_state_d;
      sync_lost_q <= sync_lost_d;
    end
  end

  assign kb_rdn    = kb_rdn_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign key_ext   = key_ext_q;
  assign key_break = key_break_q;
  assign key_state = key_state_q;
  assign sync_lost = sync_lost_q;

`ifdef PS2_SCANCODE_ASCII_EN
  // shift_q[0] = left shift (12), shift_q[1] = right shift (59).
  logic [1:0] shift_q, shift_d;
  logic [7:0] ascii_q, ascii_d;

  function automatic logic [7:0] set2_ascii(input logic [7:0] code, input logic shifted);
    logic [7:0] ch;
    ch = 8'h00;
    case (code)
      8'h1C: ch = 8'h61;  8'h32: ch = 8'h62;  8'h21: ch = 8'h63;  8'h23: ch = 8'h64;
      8'h24: ch = 8'h65;  8'h2B: ch = 8'h66;  8'h34: ch = 8'h67;  8'h33: ch = 8'h68;
      8'h43: ch = 8'h69;  8'h3B: ch = 8'h6A;  8'h42: ch = 8'h6B;  8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D;  8'h31: ch = 8'h6E;  8'h44: ch = 8'h6F;  8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71;  8'h2D: ch = 8'h72;  8'h1B: ch = 8'h73;  8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75;  8'h2A: ch = 8'h76;  8'h1D: ch = 8'h77;  8'h22: ch = 8'h78;
      8'h35: ch = 8'h79;  8'h1A: ch = 8'h7A;
      8'h45: ch = 8'h30;  8'h16: ch = 8'h31;  8'h1E: ch = 8'h32;  8'h26: ch = 8'h33;
      8'h25: ch = 8'h34;  8'h2E: ch = 8'h35;  8'h36: ch = 8'h36;  8'h3D: ch = 8'h37;
      8'h3E: ch = 8'h38;  8'h46: ch = 8'h39;
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0D;
      default: ch = 8'h00;
    endcase
    // Only letters change case; digits are unshifted symbols here.
    if (shifted && (ch >= 8'h61) && (ch <= 8'h7A)) ch = ch - 8'h20;
    return ch;
  endfunction

  always_comb begin
    shift_d = shift_q;
    ascii_d = ascii_q;
    if (key_valid_d) begin
      ascii_d = (!ext_f_q && !brk_f_q) ? set2_ascii(byte_q, |shift_q) : 8'h00;
      if (!ext_f_q && (byte_q == 8'h12)) shift_d[0] = !brk_f_q;
      if (!ext_f_q && (byte_q == 8'h59)) shift_d[1] = !brk_f_q;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      shift_q <= 2'b00;
      ascii_q <= 8'h00;
    end else begin
      shift_q <= shift_d;
      ascii_q <= ascii_d;
    end
  end

  assign key_ascii = ascii_q;
`else
  assign key_ascii = 8'h00;
`endif

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// tb/tb_ps2_scancode_decoder.sv - self-checking bench for ps2_scancode_decoder
module tb_ps2_scancode_decoder;

  logic       clk = 1'b0;
  logic       clrn = 1'b0;
  logic [7:0] kb_data = 8'h00;
  logic       kb_ready = 1'b0;
  logic       kb_overflow = 1'b0;
  logic       kb_rdn, key_valid, key_ext, key_break, sync_lost;
  logic [7:0] key_code, key_state, key_ascii;

  ps2_scancode_decoder dut (
    .clk(clk), .clrn(clrn), .kb_data(kb_data), .kb_ready(kb_ready),
    .kb_overflow(kb_overflow), .kb_rdn(kb_rdn), .key_valid(key_valid),
    .key_code(key_code), .key_ext(key_ext), .key_break(key_break),
    .key_state(key_state), .sync_lost(sync_lost), .key_ascii(key_ascii)
  );

  always #10 clk = ~clk;

`ifdef PS2_SCANCODE_ASCII_EN
  localparam bit ASCII_ON = 1'b1;
`else
  localparam bit ASCII_ON = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic [7:0] ascii;
    logic [7:0] state;
  } ev_t;

  localparam logic [7:0] LETTERS [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B,
    8'h34, 8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15,
    8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  localparam logic [7:0] DIGITS [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E,
    8'h36, 8'h3D, 8'h3E, 8'h46};
  // Game keys in key_state bit order; bits 4..7 need the E0 prefix.
  localparam logic [7:0] GAME_KEYS [8] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72, 8'h74};
  localparam logic [7:0] POOL [24] = '{8'h1D, 8'h1C, 8'h1B, 8'h23, 8'h75, 8'h6B, 8'h72,
    8'h74, 8'hE0, 8'hE0, 8'hF0, 8'hF0, 8'h12, 8'h59, 8'h29, 8'h5A, 8'h16, 8'h45,
    8'h32, 8'h4D, 8'hE1, 8'hAA, 8'hFA, 8'h34};

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int rdn_double = 0;
  bit prev_rdn_low = 1'b0;
  logic [7:0] rxq[$];
  ev_t obs[$], exp_q[$];
  int  obs_cyc[$], rdn_cyc[$];

  // Reference state, kept as the spec's notions rather than hardware registers.
  bit       m_ext, m_brk, m_sync, m_lshift, m_rshift;
  int       m_skip;
  logic [7:0] m_state;

  function automatic logic [7:0] ref_ascii(input logic [7:0] c, input bit shifted);
    for (int i = 0; i < 26; i++)
      if (LETTERS[i] == c) return (shifted ? 8'h41 : 8'h61) + 8'(i);
    for (int i = 0; i < 10; i++)
      if (DIGITS[i] == c) return 8'h30 + 8'(i);
    if (c == 8'h29) return 8'h20;
    if (c == 8'h5A) return 8'h0D;
    return 8'h00;
  endfunction

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_sync = 0; m_lshift = 0; m_rshift = 0; m_skip = 0; m_state = 8'h00;
  endtask

  task automatic model_byte(input logic [7:0] b);
    ev_t e;
    if (m_skip > 0) m_skip--;
    else if (b == 8'hE1) begin m_skip = 7; m_ext = 0; m_brk = 0; end
    else if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else if (b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF}) begin
      if (b inside {8'hAA, 8'hFE, 8'h00, 8'hFF}) begin m_sync = 1; m_state = 8'h00; end
      m_ext = 0; m_brk = 0;
    end else begin
      for (int i = 0; i < 8; i++)
        if (GAME_KEYS[i] == b && (i >= 4) == m_ext) m_state[i] = !m_brk;
      e.code  = b;
      e.ext   = m_ext;
      e.brk   = m_brk;
      e.ascii = (ASCII_ON && !m_ext && !m_brk) ? ref_ascii(b, m_lshift || m_rshift) : 8'h00;
      e.state = m_state;
      if (!m_ext && b == 8'h12) m_lshift = !m_brk;
      if (!m_ext && b == 8'h59) m_rshift = !m_brk;
      exp_q.push_back(e);
      m_ext = 0; m_brk = 0;
    end
  endtask

  task automatic send(input logic [7:0] b);
    rxq.push_back(b);
    model_byte(b);
  endtask

  task automatic clear_logs();
    obs.delete(); obs_cyc.delete(); exp_q.delete();
  endtask

  // Waits for the receiver queue to drain, then lets the last byte decode.
  task automatic settle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      if (rxq.size() == 0 && !kb_ready) begin ok = 1'b1; break; end
    end
    repeat (6) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Receiver FIFO: pops the head after a cycle in which kb_rdn was low.
  initial forever begin
    bit rdn_seen;
    @(negedge clk);
    rdn_seen = !kb_rdn;
    @(posedge clk);
    #1;
    if (rdn_seen && rxq.size() > 0) void'(rxq.pop_front());
    kb_ready = (rxq.size() > 0);
    kb_data  = (rxq.size() > 0) ? rxq[0] : 8'h00;
  end

  initial forever begin
    @(negedge clk);
    if (!kb_rdn) begin
      rdn_cyc.push_back(cyc);
      if (prev_rdn_low) rdn_double++;
    end
    prev_rdn_low = !kb_rdn;
    if (key_valid) begin
      obs.push_back(ev_t'{key_code, key_ext, key_break, key_ascii, key_state});
      obs_cyc.push_back(cyc);
    end
  end

  task automatic test_reset();
    clrn = 1'b0;
    repeat (3) @(negedge clk);
    tests++; if (kb_rdn !== 1'b1) begin fails++; $display("FAIL reset_rdn got %b want 1", kb_rdn); end
    tests++; if (key_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", key_valid); end
    tests++; if ({key_code, key_ext, key_break} !== 10'h000) begin fails++; $display("FAIL reset_fields got %h/%b/%b want 00/0/0", key_code, key_ext, key_break); end
    tests++; if (key_state !== 8'h00) begin fails++; $display("FAIL reset_state got %h want 00", key_state); end
    tests++; if (sync_lost !== 1'b0) begin fails++; $display("FAIL reset_sync got %b want 0", sync_lost); end
    tests++; if (key_ascii !== 8'h00) begin fails++; $display("FAIL reset_ascii got %h want 00", key_ascii); end
    clrn = 1'b1;
    model_reset();
    repeat (4) @(negedge clk);
    tests++; if (rdn_cyc.size() != 0) begin fails++; $display("FAIL idle_rdn got %0d strobes want 0", rdn_cyc.size()); end
  endtask

  task automatic test_make_break();
    bit ok;
    clear_logs();
    send(8'h1D);
    settle(ok);
    send(8'hF0); send(8'h1D);
    settle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL make_break timeout got stuck want drained"); end
    tests++; if (obs.size() != exp_q.size()) begin fails++; $display("FAIL make_break count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      tests++; if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL make_break ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_extended();
    bit ok;
    clear_logs();
    send(8'hE0); send(8'h75);
    settle(ok);
    tests++; if (key_state !== 8'h10) begin fails++; $display("FAIL ext_make_state got %h want 10", key_state); end
    send(8'hE0); send(8'hF0); send(8'h75);
    settle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL extended timeout got stuck want drained"); end
    tests++; if (obs.size() != exp_q.size()) begin fails++; $display("FAIL extended count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      tests++; if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL extended ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_pause();
    bit ok;
    logic [7:0] seq [9] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77, 8'h1C};
    clear_logs();
    for (int i = 0; i < 9; i++) send(seq[i]);
    settle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL pause timeout got stuck want drained"); end
    tests++; if (obs.size() != 1) begin fails++; $display("FAIL pause count got %0d want 1", obs.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      tests++; if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL pause ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    tests++; if (key_state !== 8'h02) begin fails++; $display("FAIL pause_state got %h want 02", key_state); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int r0;
    clear_logs();
    r0 = rdn_cyc.size();
    for (int i = 0; i < 4; i++) send(GAME_KEYS[$urandom_range(0, 3)]);
    settle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL b2b timeout got stuck want drained"); end
    tests++; if (rdn_cyc.size() - r0 != 4) begin fails++; $display("FAIL b2b strobes got %0d want 4", rdn_cyc.size() - r0); end
    tests++; if (obs.size() != 4) begin fails++; $display("FAIL b2b events got %0d want 4", obs.size()); end
    for (int i = 1; i < 4 && r0 + i < rdn_cyc.size(); i++) begin
      tests++; if (rdn_cyc[r0+i] - rdn_cyc[r0+i-1] != 3) begin fails++; $display("FAIL b2b spacing%0d got %0d want 3", i, rdn_cyc[r0+i] - rdn_cyc[r0+i-1]); end
    end
    for (int i = 0; i < obs.size() && i < exp_q.size() && r0 + i < rdn_cyc.size(); i++) begin
      tests++; if (obs_cyc[i] - rdn_cyc[r0+i] != 2) begin fails++; $display("FAIL b2b latency%0d got %0d want 2", i, obs_cyc[i] - rdn_cyc[r0+i]); end
      tests++; if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL b2b ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_overflow();
    bit ok;
    clear_logs();
    send(8'hE0);
    settle(ok);
    @(negedge clk); kb_overflow = 1'b1;
    @(negedge clk); kb_overflow = 1'b0;
    m_sync = 1; m_ext = 0; m_brk = 0; m_skip = 0;
    tests++; if (sync_lost !== 1'b1) begin fails++; $display("FAIL ovf_sync got %b want 1", sync_lost); end
    send(8'h75);
    settle(ok);
    tests++; if (obs.size() != 1) begin fails++; $display("FAIL ovf count got %0d want 1", obs.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      tests++; if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL ovf ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    send(8'hAA);
    settle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL ovf timeout got stuck want drained"); end
    tests++; if (sync_lost !== 1'b1) begin fails++; $display("FAIL bat_sync got %b want 1", sync_lost); end
    tests++; if (key_state !== m_state) begin fails++; $display("FAIL bat_state got %h want %h", key_state, m_state); end
  endtask

`ifdef PS2_SCANCODE_ASCII_EN
  task automatic test_ascii();
    bit ok;
    logic [7:0] seq [6] = '{8'h1C, 8'h12, 8'h1C, 8'hF0, 8'h12, 8'h1C};
    logic [7:0] want [5] = '{8'h61, 8'h00, 8'h41, 8'h00, 8'h61};
    clear_logs();
    for (int i = 0; i < 6; i++) send(seq[i]);
    settle(ok);
    tests++; if (obs.size() != 5) begin fails++; $display("FAIL ascii count got %0d want 5", obs.size()); end
    for (int i = 0; i < obs.size() && i < 5; i++) begin
      tests++; if (obs[i].ascii !== want[i]) begin fails++; $display("FAIL ascii ev%0d got %h want %h", i, obs[i].ascii, want[i]); end
    end
  endtask
`endif

  task automatic test_random();
    bit ok;
    clear_logs();
    for (int k = 0; k < 40; k++) begin
      send(POOL[$urandom_range(0, 23)]);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    settle(ok);
    tests++; if (!ok) begin fails++; $display("FAIL random timeout got stuck want drained"); end
    tests++; if (obs.size() != exp_q.size()) begin fails++; $display("FAIL random count got %0d want %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      tests++; if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL random ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
    tests++; if ({key_state, sync_lost} !== {m_state, m_sync}) begin fails++; $display("FAIL random_final got %h/%b want %h/%b", key_state, sync_lost, m_state, m_sync); end
  endtask

  task automatic test_reset_mid_fetch();
    bit ok, got;
    got = 1'b0;
    rxq.push_back(8'h1D);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!kb_rdn) begin got = 1'b1; break; end
    end
    tests++; if (!got) begin fails++; $display("FAIL midfetch_strobe got none want low"); end
    #2 clrn = 1'b0;
    #1;
    tests++; if (kb_rdn !== 1'b1) begin fails++; $display("FAIL midfetch_rdn got %b want 1", kb_rdn); end
    tests++; if ({key_valid, key_code, key_ext, key_break, key_state, sync_lost, key_ascii} !== 28'h0) begin
      fails++; $display("FAIL midfetch_outputs got %b/%h/%b/%b/%h/%b/%h want all zero", key_valid, key_code, key_ext, key_break, key_state, sync_lost, key_ascii);
    end
    @(negedge clk); rxq.delete();
    @(negedge clk); clrn = 1'b1;
    model_reset();
    clear_logs();
    send(8'h1C);
    settle(ok);
    tests++; if (obs.size() != 1) begin fails++; $display("FAIL post_reset count got %0d want 1", obs.size()); end
    for (int i = 0; i < obs.size() && i < exp_q.size(); i++) begin
      tests++; if (obs[i] !== exp_q[i]) begin fails++; $display("FAIL post_reset ev%0d got %h want %h", i, obs[i], exp_q[i]); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_make_break();
    test_extended();
    test_pause();
    test_back_to_back();
    test_overflow();
`ifdef PS2_SCANCODE_ASCII_EN
    test_ascii();
`endif
    test_random();
    test_reset_mid_fetch();
    tests++; if (rdn_double != 0) begin fails++; $display("FAIL rdn_double got %0d want 0", rdn_double); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
